// File: rtl/dds_pkg.sv
// Shared constants for the DDS waveform generator: wave-select codes,
// control FSM encoding and the output midscale value.
package dds_pkg;

   localparam logic [1:0] WAVE_SQR = 2'b00;
   localparam logic [1:0] WAVE_SAW = 2'b01;
   localparam logic [1:0] WAVE_TRI = 2'b10;
   localparam logic [1:0] WAVE_SIN = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [7:0] MIDSCALE = 8'd128;

endpackage

// File: rtl/sine_qlut.sv
// Quarter-wave sine ROM: value(i) = round(127*sin((i+0.5)*pi/128)), i = 0..63.
// Half-step offset keeps the quarters mirror-symmetric without a duplicated peak.
module sine_qlut (
   input  logic [5:0] addr,
   output logic [6:0] value
);

   always_comb begin
      // NOTE: every combinational output gets a default before the case so no latch is inferred.
      value = 7'd0;
      case (addr)
         6'd0:  value = 7'd2;    6'd1:  value = 7'd5;    6'd2:  value = 7'd8;    6'd3:  value = 7'd11;
         6'd4:  value = 7'd14;   6'd5:  value = 7'd17;   6'd6:  value = 7'd20;   6'd7:  value = 7'd23;
         6'd8:  value = 7'd26;   6'd9:  value = 7'd29;   6'd10: value = 7'd32;   6'd11: value = 7'd35;
         6'd12: value = 7'd38;   6'd13: value = 7'd41;   6'd14: value = 7'd44;   6'd15: value = 7'd47;
         6'd16: value = 7'd50;   6'd17: value = 7'd53;   6'd18: value = 7'd56;   6'd19: value = 7'd58;
         6'd20: value = 7'd61;   6'd21: value = 7'd64;   6'd22: value = 7'd67;   6'd23: value = 7'd69;
         6'd24: value = 7'd72;   6'd25: value = 7'd74;   6'd26: value = 7'd77;   6'd27: value = 7'd79;
         6'd28: value = 7'd82;   6'd29: value = 7'd84;   6'd30: value = 7'd86;   6'd31: value = 7'd89;
         6'd32: value = 7'd91;   6'd33: value = 7'd93;   6'd34: value = 7'd95;   6'd35: value = 7'd97;
         6'd36: value = 7'd99;   6'd37: value = 7'd101;  6'd38: value = 7'd103;  6'd39: value = 7'd105;
         6'd40: value = 7'd106;  6'd41: value = 7'd108;  6'd42: value = 7'd110;  6'd43: value = 7'd111;
         6'd44: value = 7'd113;  6'd45: value = 7'd114;  6'd46: value = 7'd115;  6'd47: value = 7'd117;
         6'd48: value = 7'd118;  6'd49: value = 7'd119;  6'd50: value = 7'd120;  6'd51: value = 7'd121;
         6'd52: value = 7'd122;  6'd53: value = 7'd123;  6'd54: value = 7'd124;  6'd55: value = 7'd124;
         6'd56: value = 7'd125;  6'd57: value = 7'd125;  6'd58: value = 7'd126;  6'd59: value = 7'd126;
         6'd60: value = 7'd127;  6'd61: value = 7'd127;  6'd62: value = 7'd127;  6'd63: value = 7'd127;
         default: value = 7'd0;
      endcase
   end

endmodule

// File: rtl/dds_wave_gen.sv
// DDS waveform generator: phase accumulator advanced on each dds_clk strobe,
// registered square/saw/triangle/sine sample. Optional AMP_SCALE_EN adds amp_shift.
module dds_wave_gen
   import dds_pkg::*;
#(
   parameter int PH_W  = 8,
   parameter int OUT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dds_clk,
   input  logic             run,
   input  logic [1:0]       wave_sel,
   input  logic [PH_W-1:0]  phase_step,
`ifdef AMP_SCALE_EN
   input  logic [1:0]       amp_shift,
`endif
   output logic [OUT_W-1:0] wave_out,
   output logic             sample_valid,
   output logic             period_done,
   output logic             busy
);

   state_t            state_q, state_d;
   logic [PH_W-1:0]   phase_q;
   logic [PH_W:0]     sum;
   logic              carry;
   logic [5:0]        lut_addr;
   logic [6:0]        lut_val;
   logic [OUT_W-1:0]  raw;
   logic [OUT_W-1:0]  sample;

   assign sum      = {1'b0, phase_q} + {1'b0, phase_step};
   assign carry    = sum[PH_W];
   assign busy     = (state_q != IDLE);
   // Second and fourth quarters read the table backwards.
   assign lut_addr = phase_q[6] ? ~phase_q[5:0] : phase_q[5:0];

   sine_qlut u_sine_qlut (
      .addr  (lut_addr),
      .value (lut_val)
   );

   always_comb begin
      raw = MIDSCALE;
      case (wave_sel)
         WAVE_SQR: raw = phase_q[7] ? 8'd0 : 8'd255;
         WAVE_SAW: raw = phase_q;
         WAVE_TRI: raw = phase_q[7] ? ~{phase_q[6:0], 1'b0} : {phase_q[6:0], 1'b0};
         WAVE_SIN: raw = phase_q[7] ? (8'd127 - {1'b0, lut_val}) : (8'd128 + {1'b0, lut_val});
      endcase
   end

`ifdef AMP_SCALE_EN
   logic signed [8:0] centred, scaled, biased;
   always_comb begin
      centred = $signed({1'b0, raw}) - 9'sd128;
      scaled  = centred >>> amp_shift;
      biased  = scaled + 9'sd128;
      sample  = biased[OUT_W-1:0];
   end
`else
   assign sample = raw;
`endif

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Strobe coincident with a run edge is handled by the pre-edge state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (run) state_d = RUN;
         RUN:     if (!run) state_d = DRAIN;
         DRAIN: begin
            if (dds_clk && carry) state_d = IDLE;
            else if (run)         state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         phase_q      <= '0;
         wave_out     <= MIDSCALE;
         sample_valid <= 1'b0;
         period_done  <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         period_done  <= 1'b0;
         if (dds_clk && state_q != IDLE) begin
            sample_valid <= 1'b1;
            period_done  <= carry;
            if (state_q == DRAIN && carry) begin
               phase_q  <= '0;
               wave_out <= MIDSCALE;
            end else begin
               phase_q  <= sum[PH_W-1:0];
               wave_out <= sample;
            end
         end
      end
   end

endmodule

// File: tb/tb_dds_wave_gen.sv
// Self-checking bench for dds_wave_gen: directed scenarios plus randomized
// traffic, every cycle compared against a behavioural reference model.
module tb_dds_wave_gen;

   localparam real PI = 3.14159265358979323846;

   logic       clk = 1'b0;
   logic       reset, dds_clk, run;
   logic [1:0] wave_sel;
   logic [7:0] phase_step;
`ifdef AMP_SCALE_EN
   logic [1:0] amp_shift;
`endif
   logic [7:0] wave_out;
   logic       sample_valid, period_done, busy;

   int tests  = 0;
   int failed = 0;

   int m_phase, m_wave;
   bit m_valid, m_done, m_busy, m_stopping;

   int cap_wave[$];
   bit cap_done[$];

   always #5 clk = ~clk;

   dds_wave_gen dut (
      .clk          (clk),
      .reset        (reset),
      .dds_clk      (dds_clk),
      .run          (run),
      .wave_sel     (wave_sel),
      .phase_step   (phase_step),
`ifdef AMP_SCALE_EN
      .amp_shift    (amp_shift),
`endif
      .wave_out     (wave_out),
      .sample_valid (sample_valid),
      .period_done  (period_done),
      .busy         (busy)
   );

   initial begin
      #1ms;
      $display("FAIL watchdog: observed timeout, required finish");
      $fatal(1);
   end

   function automatic int ideal_sample(int sel, int p, int sh);
      int raw, q, idx, v;
      case (sel)
         0: raw = (p < 128) ? 255 : 0;
         1: raw = p;
         2: raw = (p < 128) ? 2 * p : 255 - 2 * (p - 128);
         default: begin
            q   = p % 128;
            idx = (q < 64) ? q : 127 - q;
            v   = int'($floor(127.0 * $sin((real'(idx) + 0.5) * PI / 128.0) + 0.5));
            raw = (p < 128) ? 128 + v : 127 - v;
         end
      endcase
      return 128 + ((raw - 128) >>> sh);
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference behaviour for one clock edge, from the inputs present now.
   task automatic model_edge();
      bit was_busy, was_stopping, wrap_stop;
      int nxt, sh;
      sh = 0;
`ifdef AMP_SCALE_EN
      sh = int'(amp_shift);
`endif
      if (reset) begin
         m_phase = 0; m_wave = 128; m_valid = 0; m_done = 0; m_busy = 0; m_stopping = 0;
         return;
      end
      was_busy     = m_busy;
      was_stopping = m_stopping;
      wrap_stop    = 0;
      m_valid      = 0;
      m_done       = 0;
      if (dds_clk && was_busy) begin
         nxt     = m_phase + int'(phase_step);
         m_valid = 1;
         m_done  = (nxt > 255);
         if (was_stopping && nxt > 255) begin
            wrap_stop = 1;
            m_phase   = 0;
            m_wave    = 128;
         end else begin
            m_wave  = ideal_sample(int'(wave_sel), m_phase, sh);
            m_phase = nxt % 256;
         end
      end
      if (!was_busy) begin
         if (run) begin m_busy = 1; m_stopping = 0; end
      end else if (wrap_stop) begin
         m_busy = 0; m_stopping = 0;
      end else begin
         m_stopping = !run;
      end
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
      check("wave_out", wave_out, m_wave);
      check("sample_valid", sample_valid, m_valid);
      check("period_done", period_done, m_done);
      check("busy", busy, m_busy);
      if (sample_valid === 1'b1) begin
         cap_wave.push_back(int'(wave_out));
         cap_done.push_back(period_done);
      end
   endtask

   task automatic idle_cycles(int n);
      dds_clk = 1'b0;
      repeat (n) cycle();
   endtask

   task automatic strobes(int n, int gap);
      for (int i = 0; i < n; i++) begin
         dds_clk = 1'b1;
         cycle();
         dds_clk = 1'b0;
         repeat (gap - 1) cycle();
      end
   endtask

   task automatic start(logic [1:0] sel, logic [7:0] step);
      reset      = 1'b1;
      run        = 1'b0;
      dds_clk    = 1'b0;
      wave_sel   = sel;
      phase_step = step;
      repeat (2) cycle();
      check("reset_wave", wave_out, 128);
      check("reset_busy", busy, 0);
      reset = 1'b0;
      run   = 1'b1;
      cycle();
      cap_wave.delete();
      cap_done.delete();
   endtask

   initial begin
      int exp_q[$];
      int dsum;
      reset = 1'b1; run = 1'b0; dds_clk = 1'b0; wave_sel = 2'b00; phase_step = 8'd0;
`ifdef AMP_SCALE_EN
      amp_shift = 2'd0;
`endif

      // Saw, step 32, strobe every 4 clocks
      start(2'b01, 8'd32);
      dds_clk = 1'b1;
      cycle();
      check("latency_valid", sample_valid, 1);
      dds_clk = 1'b0;
      cycle();
      check("valid_one_cycle", sample_valid, 0);
      idle_cycles(2);
      strobes(8, 4);
      check("saw_count", cap_wave.size(), 9);
      for (int k = 0; k < 9; k++) begin
         check("saw_seq", cap_wave[k], (k * 32) % 256);
         check("saw_done", cap_done[k], (k == 7));
      end

      // Square / triangle / sine at step 64
      start(2'b00, 8'd64);
      strobes(4, 3);
      exp_q = '{255, 255, 0, 0};
      foreach (exp_q[k]) check("square_seq", cap_wave[k], exp_q[k]);

      start(2'b10, 8'd64);
      strobes(4, 3);
      exp_q = '{0, 128, 255, 127};
      foreach (exp_q[k]) check("tri_seq", cap_wave[k], exp_q[k]);

      start(2'b11, 8'd64);
      strobes(4, 3);
      exp_q = '{130, 255, 125, 0};
      foreach (exp_q[k]) check("sine_seq", cap_wave[k], exp_q[k]);

      // Sine, step 1, full period
      start(2'b11, 8'd1);
      strobes(256, 2);
      check("sine_count", cap_wave.size(), 256);
      dsum = 0;
      for (int k = 0; k < 255; k++) dsum += int'(cap_done[k]);
      check("sine_no_early_done", dsum, 0);
      check("sine_done_last", cap_done[255], 1);
      for (int i = 0; i < 64; i++) begin
         check("sine_mirror", cap_wave[i] - cap_wave[127 - i], 0);
         check("sine_halfwave", cap_wave[i] + cap_wave[i + 128], 255);
      end

      // Drop run at phase 80: drain to the wrap
      start(2'b01, 8'd16);
      strobes(5, 3);
      run = 1'b0;
      strobes(11, 3);
      check("drain_count", cap_wave.size(), 16);
      check("drain_last_sample", cap_wave[14], 224);
      check("drain_wrap_mid", cap_wave[15], 128);
      check("drain_wrap_done", cap_done[15], 1);
      check("drain_idle", busy, 0);
      strobes(2, 3);
      check("idle_no_samples", cap_wave.size(), 16);

      // Drop run at 80, reassert at 160 while draining
      start(2'b01, 8'd16);
      strobes(5, 3);
      run = 1'b0;
      strobes(5, 3);
      check("drain_busy", busy, 1);
      run = 1'b1;
      strobes(8, 3);
      check("resume_count", cap_wave.size(), 18);
      check("resume_160", cap_wave[10], 160);
      check("resume_176", cap_wave[11], 176);
      check("resume_240", cap_wave[15], 240);
      check("resume_wrap_done", cap_done[15], 1);
      check("resume_wrap_zero", cap_wave[16], 0);
      check("resume_busy", busy, 1);

      // Reset coincident with a strobe mid-RUN
      start(2'b01, 8'd16);
      strobes(3, 3);
      reset   = 1'b1;
      dds_clk = 1'b1;
      run     = 1'b0;
      cycle();
      check("rst_strobe_wave", wave_out, 128);
      check("rst_strobe_valid", sample_valid, 0);
      check("rst_strobe_busy", busy, 0);
      reset   = 1'b0;
      dds_clk = 1'b0;
      strobes(3, 3);
      check("rst_no_samples", cap_wave.size(), 3);

`ifdef AMP_SCALE_EN
      amp_shift = 2'd2;
      start(2'b00, 8'd64);
      strobes(4, 3);
      exp_q = '{159, 159, 96, 96};
      foreach (exp_q[k]) check("amp2_seq", cap_wave[k], exp_q[k]);
      amp_shift = 2'd0;
      start(2'b00, 8'd64);
      strobes(4, 3);
      exp_q = '{255, 255, 0, 0};
      foreach (exp_q[k]) check("amp0_seq", cap_wave[k], exp_q[k]);
`endif

      // Randomized traffic
      start(2'($urandom), 8'($urandom));
      for (int c = 0; c < 3000; c++) begin
         reset   = ($urandom_range(0, 199) == 0);
         dds_clk = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 31) == 0) run = ~run;
         wave_sel = 2'($urandom);
         case ($urandom_range(0, 3))
            0:       phase_step = 8'd0;
            1:       phase_step = 8'(1 << $urandom_range(0, 7));
            default: phase_step = 8'($urandom);
         endcase
`ifdef AMP_SCALE_EN
         amp_shift = 2'($urandom);
`endif
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
